// File: rtl/bcd_seg_display_if.sv
// Display bus between the value source (din/dval/enable) and the 7-segment decoder.
interface bcd_seg_display_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 4
);
    logic [WIDTH-1:0]    din;
    logic                dval;
    logic                enable;
    logic                busy;
    logic                done;
    logic                overflow;
    logic [7*DIGITS-1:0] seg;

    modport master (
        output din, dval, enable,
        input  busy, done, overflow, seg
    );

    modport slave (
        input  din, dval, enable,
        output busy, done, overflow, seg
    );
endinterface

// File: rtl/bcd_seg_display.sv
// Serial double-dabble binary-to-decimal converter driving DIGITS active-low 7-seg digits.
// Define DISP_SIGNED_EN to treat din as two's complement and show a leading minus.
module bcd_seg_display #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 4,
    parameter int LZB    = 1
) (
    input logic              clk,
    input logic              resetn,
    bcd_seg_display_if.slave disp
);
    localparam int          ND = (WIDTH + 2) / 3;
    localparam int          CW = $clog2(WIDTH + 1);
    localparam int unsigned NP = (ND > DIGITS) ? ND : DIGITS;
    localparam int unsigned DG = DIGITS;
    localparam int          PW = 4 * NP;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CONV   = 2'd1;
    localparam logic [1:0] S_UPDATE = 2'd2;

    logic [1:0]          r_state;
    logic [WIDTH-1:0]    r_bin;
    logic [WIDTH-1:0]    r_pdata;
    logic [4*ND-1:0]     r_bcd;
    logic [CW-1:0]       r_cnt;
    logic                r_pend;
    logic                r_done;
    logic                r_ovf;
    logic [7*DIGITS-1:0] r_seg;

    logic [4*ND-1:0]     w_adj;
    logic [PW-1:0]       w_pad;
    logic [7*DIGITS-1:0] w_seg;
    logic                w_ovf;
    logic                w_load;
    logic [WIDTH-1:0]    w_src;
    logic                w_neg;
    int unsigned         w_msd;
    int unsigned         w_lim;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
`ifdef DISP_SIGNED_EN
        return v[WIDTH-1] ? -v : v;
`else
        return v;
`endif
    endfunction

`ifdef DISP_SIGNED_EN
    logic r_neg;
    assign w_neg = r_neg;
`else
    assign w_neg = 1'b0;
`endif

    // A pending value takes priority at UPDATE; otherwise a coincident dval loads directly.
    always_comb begin
        w_load = 1'b0;
        w_src  = disp.din;
        case (r_state)
            S_IDLE:   w_load = disp.dval;
            S_UPDATE: begin
                if (r_pend) begin
                    w_load = 1'b1;
                    w_src  = r_pdata;
                end else begin
                    w_load = disp.dval;
                end
            end
            default:  w_load = 1'b0;
        endcase
    end

    always_comb begin
        w_adj = r_bcd;
        for (int unsigned i = 0; i < ND; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    // Sign takes a digit slot, so the overflow limit drops by one for negative values.
    always_comb begin
        w_pad = PW'(r_bcd);
        w_ovf = 1'b0;
        w_msd = 0;
        w_lim = w_neg ? DG - 1 : DG;
        w_seg = '1;
        for (int unsigned i = 0; i < NP; i++) begin
            if (w_pad[4*i +: 4] != 4'd0) begin
                w_msd = i;
                if (i >= w_lim)
                    w_ovf = 1'b1;
            end
        end
        for (int unsigned k = 0; k < DG; k++) begin
            if (w_ovf)
                w_seg[7*k +: 7] = 7'h3F;
            else if (LZB != 0) begin
                if (k <= w_msd)
                    w_seg[7*k +: 7] = seg_code(w_pad[4*k +: 4]);
                else if (w_neg && (k == w_msd + 1))
                    w_seg[7*k +: 7] = 7'h3F;
                else
                    w_seg[7*k +: 7] = 7'h7F;
            end else begin
                if (w_neg && (k == DG - 1))
                    w_seg[7*k +: 7] = 7'h3F;
                else
                    w_seg[7*k +: 7] = seg_code(w_pad[4*k +: 4]);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_bin   <= '0;
            r_pdata <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_seg   <= '1;
`ifdef DISP_SIGNED_EN
            r_neg   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_load)
                        r_state <= S_CONV;
                end
                S_CONV: begin
                    r_bcd <= {w_adj[4*ND-2:0], r_bin[WIDTH-1]};
                    r_bin <= {r_bin[WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1))
                        r_state <= S_UPDATE;
                    if (disp.dval) begin
                        r_pend  <= 1'b1;
                        r_pdata <= disp.din;
                    end
                end
                S_UPDATE: begin
                    r_seg   <= w_seg;
                    r_ovf   <= w_ovf;
                    r_done  <= 1'b1;
                    r_state <= w_load ? S_CONV : S_IDLE;
                    r_pend  <= r_pend & disp.dval;
                    if (disp.dval)
                        r_pdata <= disp.din;
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_load) begin
                r_bin <= magnitude(w_src);
                r_bcd <= '0;
                r_cnt <= CW'(WIDTH);
`ifdef DISP_SIGNED_EN
                r_neg <= w_src[WIDTH-1];
`endif
            end
        end
    end

    assign disp.busy     = (r_state != S_IDLE);
    assign disp.done     = r_done;
    assign disp.overflow = r_ovf;
    assign disp.seg      = disp.enable ? r_seg : '1;
endmodule

// File: tb/tb_bcd_seg_display.sv
// Directed self-checking bench for bcd_seg_display in three configurations.
module tb_bcd_seg_display;
    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] DS = 7'h3F;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bcd_seg_display_if #(.WIDTH(8), .DIGITS(4)) ia ();
    bcd_seg_display_if #(.WIDTH(8), .DIGITS(4)) ib ();
    bcd_seg_display_if #(.WIDTH(8), .DIGITS(2)) ic ();

    bcd_seg_display #(.WIDTH(8), .DIGITS(4), .LZB(1)) u_a (.clk(clk), .resetn(resetn), .disp(ia));
    bcd_seg_display #(.WIDTH(8), .DIGITS(4), .LZB(0)) u_b (.clk(clk), .resetn(resetn), .disp(ib));
    bcd_seg_display #(.WIDTH(8), .DIGITS(2), .LZB(1)) u_c (.clk(clk), .resetn(resetn), .disp(ic));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        checks++; if (ia.seg !== '1) begin failures++; $display("FAIL reset_seg got=%h exp=%h", ia.seg, 28'hFFFFFFF); end
        checks++; if (ia.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", ia.busy); end
        checks++; if (ia.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", ia.done); end
        checks++; if (ic.overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ic.overflow); end
    endtask

`ifndef DISP_SIGNED_EN
    task automatic test_unsigned_max;
        int n;
        ia.din = 8'd255; ia.dval = 1'b1; tick; ia.dval = 1'b0;
        checks++; if (ia.busy !== 1'b1) begin failures++; $display("FAIL max_busy got=%b exp=1", ia.busy); end
        n = 0;
        while (ia.done !== 1'b1 && n < 30) begin tick; n++; end
        checks++; if (n != 9) begin failures++; $display("FAIL max_latency got=%0d exp=9", n); end
        checks++; if (ia.seg !== {BL, 7'h24, 7'h12, 7'h12}) begin failures++; $display("FAIL max_seg got=%h exp=%h", ia.seg, {BL, 7'h24, 7'h12, 7'h12}); end
        checks++; if (ia.overflow !== 1'b0) begin failures++; $display("FAIL max_ovf got=%b exp=0", ia.overflow); end
        tick;
        checks++; if (ia.done !== 1'b0) begin failures++; $display("FAIL max_done_pulse got=%b exp=0", ia.done); end
    endtask
`endif

    task automatic test_zero;
        int n;
        ia.din = 8'd0; ib.din = 8'd0; ia.dval = 1'b1; ib.dval = 1'b1; tick;
        ia.dval = 1'b0; ib.dval = 1'b0;
        n = 0;
        while (ia.done !== 1'b1 && n < 30) begin tick; n++; end
        checks++; if (n != 9) begin failures++; $display("FAIL zero_latency got=%0d exp=9", n); end
        checks++; if (ib.done !== 1'b1) begin failures++; $display("FAIL zero_b_done got=%b exp=1", ib.done); end
        checks++; if (ia.seg !== {BL, BL, BL, 7'h40}) begin failures++; $display("FAIL zero_lzb_seg got=%h exp=%h", ia.seg, {BL, BL, BL, 7'h40}); end
        checks++; if (ib.seg !== {7'h40, 7'h40, 7'h40, 7'h40}) begin failures++; $display("FAIL zero_pad_seg got=%h exp=%h", ib.seg, {7'h40, 7'h40, 7'h40, 7'h40}); end
    endtask

    task automatic test_overflow;
        int n;
        ic.din = 8'd123; ic.dval = 1'b1; tick; ic.dval = 1'b0;
        n = 0;
        while (ic.done !== 1'b1 && n < 30) begin tick; n++; end
        checks++; if (n != 9) begin failures++; $display("FAIL ovf_latency got=%0d exp=9", n); end
        checks++; if (ic.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", ic.overflow); end
        checks++; if (ic.seg !== {DS, DS}) begin failures++; $display("FAIL ovf_seg got=%h exp=%h", ic.seg, {DS, DS}); end
        ic.din = 8'd45; ic.dval = 1'b1; tick; ic.dval = 1'b0;
        n = 0;
        while (ic.done !== 1'b1 && n < 30) begin tick; n++; end
        checks++; if (ic.overflow !== 1'b0) begin failures++; $display("FAIL fit_flag got=%b exp=0", ic.overflow); end
        checks++; if (ic.seg !== {7'h19, 7'h12}) begin failures++; $display("FAIL fit_seg got=%h exp=%h", ic.seg, {7'h19, 7'h12}); end
    endtask

    task automatic test_back_to_back;
        int          ndone;
        int          t1;
        int          t2;
        logic [27:0] s1;
        logic [27:0] s2;
        ndone = 0; t1 = -1; t2 = -1; s1 = '0; s2 = '0;
        ia.din = 8'h10; ia.dval = 1'b1; tick; ia.dval = 1'b0;
        tick; tick;
        ia.din = 8'h20; ia.dval = 1'b1; tick; ia.dval = 1'b0;
        tick;
        ia.din = 8'h30; ia.dval = 1'b1; tick; ia.dval = 1'b0;
        for (int k = 6; k <= 25; k++) begin
            tick;
            if (ia.done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin t1 = k; s1 = ia.seg; end
                else if (ndone == 2) begin t2 = k; s2 = ia.seg; end
            end
        end
        checks++; if (ndone != 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", ndone); end
        checks++; if (t1 != 9) begin failures++; $display("FAIL b2b_t1 got=%0d exp=9", t1); end
        checks++; if (t2 != 18) begin failures++; $display("FAIL b2b_t2 got=%0d exp=18", t2); end
        checks++; if (s1 !== {BL, BL, 7'h79, 7'h02}) begin failures++; $display("FAIL b2b_seg1 got=%h exp=%h", s1, {BL, BL, 7'h79, 7'h02}); end
        checks++; if (s2 !== {BL, BL, 7'h19, 7'h00}) begin failures++; $display("FAIL b2b_seg2 got=%h exp=%h", s2, {BL, BL, 7'h19, 7'h00}); end
    endtask

`ifdef DISP_SIGNED_EN
    task automatic test_signed;
        int n;
        ia.din = 8'hF6; ib.din = 8'hF6; ia.dval = 1'b1; ib.dval = 1'b1; tick;
        ia.dval = 1'b0; ib.dval = 1'b0;
        n = 0;
        while (ia.done !== 1'b1 && n < 30) begin tick; n++; end
        checks++; if (ia.seg !== {BL, DS, 7'h79, 7'h40}) begin failures++; $display("FAIL neg10_lzb got=%h exp=%h", ia.seg, {BL, DS, 7'h79, 7'h40}); end
        checks++; if (ib.seg !== {DS, 7'h40, 7'h79, 7'h40}) begin failures++; $display("FAIL neg10_pad got=%h exp=%h", ib.seg, {DS, 7'h40, 7'h79, 7'h40}); end
        ia.din = 8'h80; ia.dval = 1'b1; tick; ia.dval = 1'b0;
        n = 0;
        while (ia.done !== 1'b1 && n < 30) begin tick; n++; end
        checks++; if (ia.seg !== {DS, 7'h79, 7'h24, 7'h00}) begin failures++; $display("FAIL neg128_seg got=%h exp=%h", ia.seg, {DS, 7'h79, 7'h24, 7'h00}); end
        checks++; if (ia.overflow !== 1'b0) begin failures++; $display("FAIL neg128_ovf got=%b exp=0", ia.overflow); end
    endtask
`endif

    task automatic test_enable;
        int n;
        ia.enable = 1'b0;
        ia.din = 8'd5; ia.dval = 1'b1; tick; ia.dval = 1'b0;
        checks++; if (ia.seg !== '1) begin failures++; $display("FAIL en_blank got=%h exp=%h", ia.seg, 28'hFFFFFFF); end
        n = 0;
        while (ia.done !== 1'b1 && n < 30) begin tick; n++; end
        checks++; if (n != 9) begin failures++; $display("FAIL en_latency got=%0d exp=9", n); end
        checks++; if (ia.seg !== '1) begin failures++; $display("FAIL en_blank_done got=%h exp=%h", ia.seg, 28'hFFFFFFF); end
        ia.enable = 1'b1;
        #1;
        checks++; if (ia.seg !== {BL, BL, BL, 7'h12}) begin failures++; $display("FAIL en_restore got=%h exp=%h", ia.seg, {BL, BL, BL, 7'h12}); end
    endtask

    task automatic test_reset_mid;
        int ndone;
        ia.din = 8'h10; ia.dval = 1'b1; tick; ia.dval = 1'b0;
        repeat (4) tick;
        resetn = 1'b0;
        #1;
        checks++; if (ia.seg !== '1) begin failures++; $display("FAIL rmid_seg got=%h exp=%h", ia.seg, 28'hFFFFFFF); end
        checks++; if (ia.busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", ia.busy); end
        tick;
        resetn = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            tick;
            if (ia.done === 1'b1) ndone++;
        end
        checks++; if (ndone != 0) begin failures++; $display("FAIL rmid_done got=%0d exp=0", ndone); end
        checks++; if (ia.seg !== '1) begin failures++; $display("FAIL rmid_hold got=%h exp=%h", ia.seg, 28'hFFFFFFF); end
    endtask

    initial begin
        ia.din = '0; ia.dval = 1'b0; ia.enable = 1'b1;
        ib.din = '0; ib.dval = 1'b0; ib.enable = 1'b1;
        ic.din = '0; ic.dval = 1'b0; ic.enable = 1'b1;
        resetn = 1'b0;
        repeat (3) tick;
        test_reset;
        resetn = 1'b1;
        tick;
`ifndef DISP_SIGNED_EN
        test_unsigned_max;
`endif
        test_zero;
        test_overflow;
        test_back_to_back;
`ifdef DISP_SIGNED_EN
        test_signed;
`endif
        test_enable;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
